// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit, 2-bit-opcode CPU: opcodes, instruction field
// positions and the fetch FSM state type.
package cpu_pkg;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  localparam int OPC_HI    = 7;
  localparam int OPC_LO    = 6;
  localparam int RS_HI     = 5;
  localparam int RS_LO     = 4;
  localparam int RT_HI     = 3;
  localparam int RT_LO     = 2;
  localparam int RD_IMM_HI = 1;
  localparam int RD_IMM_LO = 0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  function automatic logic is_jump(input logic [1:0] opc);
    return opc == OP_J;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous prefetch FIFO. Flush clears everything (after any pop) and
// beats a simultaneous push; the head holds its last shown value while empty.
module fetch_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_nonempty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_nonempty = r_count != '0;
  assign w_do_pop   = i_pop && w_nonempty;
  assign w_do_push  = i_push && !i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      // Track the visible head so it can be replayed once the queue drains.
      if (w_nonempty) begin
        r_last <= r_mem[r_rptr];
      end
      if (i_flush) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) begin
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_do_pop) begin
          r_rptr <= r_rptr + AW'(1);
        end
        unique case ({w_do_push, w_do_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign o_head  = w_nonempty ? r_mem[r_rptr] : r_last;
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one imem request at a time,
// buffers words in a prefetch queue and stalls after a jump until redirected.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [1:0]         dec_opcode,
  output logic [PC_W-1:0]    dec_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               busy
);

  localparam int QW = PC_W + INSTR_W;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t        r_state;
  fetch_state_t        w_next;
  logic [PC_W-1:0]     r_fetch_pc;
  logic [PC_W-1:0]     r_req_addr;
  logic [QW-1:0]       w_head;
  logic [CW-1:0]       w_count;
  logic                w_has_room;
  logic                w_push;
  logic                w_pop;
  logic                w_outstanding;

  assign w_has_room    = w_count != CW'(DEPTH);
  assign w_outstanding = (r_state == WAIT) || (r_state == DROP);
  assign w_push        = (r_state == WAIT) && imem_ack && !redirect_valid;
  assign w_pop         = dec_valid && dec_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      FETCH: if (w_has_room) w_next = WAIT;
      WAIT:  if (imem_ack) w_next = is_jump(imem_rdata[INSTR_W-1 -: 2]) ? HOLD : FETCH;
      DROP:  if (imem_ack) w_next = FETCH;
      HOLD:  w_next = HOLD;
      default: w_next = FETCH;
    endcase
    // A request still in flight after the redirect must be drained as stale.
    if (redirect_valid) begin
      w_next = (w_outstanding && !imem_ack) ? DROP : FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH;
      r_fetch_pc <= '0;
      r_req_addr <= '0;
    end else begin
      r_state <= w_next;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_target;
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + PC_W'(1);
      end
      if (r_state == FETCH && w_next == WAIT) begin
        r_req_addr <= r_fetch_pc;
      end
    end
  end

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_din   ({r_fetch_pc, imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign imem_req   = w_outstanding;
  assign imem_addr  = r_req_addr;
  assign dec_valid  = w_count != '0;
  assign dec_pc     = w_head[QW-1 -: PC_W];
  assign dec_instr  = w_head[INSTR_W-1:0];
  assign dec_opcode = w_head[INSTR_W-1 -: 2];
  assign busy       = w_outstanding || (w_count != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: expected fetch stream comes from program order over a model
// memory; a negedge monitor pops and compares every accepted decode word.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = '0;
  logic       dec_valid;
  logic       dec_ready = 1'b0;
  logic [7:0] dec_instr;
  logic [1:0] dec_opcode;
  logic [7:0] dec_pc;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_target = '0;
  logic       busy;

  instr_fetch_unit #(.PC_W(8), .INSTR_W(8), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_opcode(dec_opcode), .dec_pc(dec_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .busy(busy)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          pops = 0;
  logic [7:0]  last_pc = '0;
  logic [7:0]  mem [256];
  logic [7:0]  req_log [$];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  logic [7:0]  m_pc;
  bit          m_end;
  bit          pending = 0;
  int          lat = 0;
  int          lat_mode = -1;
  logic [7:0]  paddr = '0;
  int          idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-order stream: sequential PCs until (and including) a jump word.
  task automatic fill();
    while (exp_q.size() < 8 && !m_end) begin
      exp_q.push_back({m_pc, mem[m_pc]});
      if (mem[m_pc][7:6] == 2'b11) m_end = 1;
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic restart(input logic [7:0] pc);
    exp_q.delete();
    m_pc  = pc;
    m_end = 0;
    fill();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      restart(8'h00);
    end else begin
      if (dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop: got pc %0h expected no delivery at %0t", dec_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dec_pc", dec_pc, mon_e[15:8]);
          chk("dec_instr", dec_instr, mon_e[7:0]);
          chk("dec_opcode", dec_opcode, mon_e[7:6]);
        end
        pops++;
        last_pc = dec_pc;
        fill();
      end
      if (redirect_valid) restart(redirect_target);
    end
  end

  task automatic respond();
    imem_ack = 1'b0;
    if (reset || !imem_req) begin
      pending = 0;
      return;
    end
    if (!pending) begin
      pending = 1;
      paddr   = imem_addr;
      req_log.push_back(imem_addr);
      lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
    end else begin
      chk("addr_stable", imem_addr, paddr);
    end
    if (lat == 0) begin
      imem_ack   = 1'b1;
      imem_rdata = mem[paddr];
      pending    = 0;
    end else begin
      lat--;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    respond();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    redirect_valid = 1'b0;
    dec_ready = 1'b0;
    repeat (n) cyc();
    reset = 1'b0;
    req_log.delete();
    pops = 0;
  endtask

  task automatic load_mem(input bit allow_jumps);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      if (!allow_jumps && v[7:6] == 2'b11) v[7:6] = 2'b10;
      mem[i] = v;
    end
  endtask

  initial begin
    load_mem(0);
    do_reset(2);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", dec_pc, 0);
    chk("rst_instr", dec_instr, 0);
    chk("rst_opcode", dec_opcode, 0);

    // Sequential fetch, one-cycle memory latency
    lat_mode = 1;
    dec_ready = 1'b1;
    repeat (30) cyc();
    chk("t1_nreq", req_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < req_log.size(); i++) chk("t1_addr", req_log[i], i);
    chk("t1_pops", pops >= 5, 1);

    // Backpressure: queue fills after two words, then one pop frees one slot
    lat_mode = 0;
    do_reset(2);
    repeat (12) cyc();
    chk("t2_nreq", req_log.size(), 2);
    for (int i = 0; i < 2 && i < req_log.size(); i++) chk("t2_addr", req_log[i], i);
    chk("t2_req_idle", imem_req, 0);
    chk("t2_valid", dec_valid, 1);
    lat_mode = 2;
    dec_ready = 1'b1;
    cyc();
    dec_ready = 1'b0;
    for (int i = 0; i < 10 && !imem_ack; i++) cyc();
    chk("t2_ack_seen", imem_ack, 1);
    chk("t2_one_more", req_log.size(), 3);
    if (req_log.size() >= 3) chk("t2_addr2", req_log[2], 2);
    // Redirect lands together with the ack: word dropped, queue flushed
    redirect_valid = 1'b1;
    redirect_target = 8'h80;
    cyc();
    redirect_valid = 1'b0;
    chk("t5_valid_flushed", dec_valid, 0);
    chk("t5_pops", pops, 1);
    lat_mode = 1;
    dec_ready = 1'b1;
    for (int i = 0; i < 10 && req_log.size() < 4; i++) cyc();
    if (req_log.size() >= 4) chk("t5_target", req_log[3], 8'h80);
    else chk("t5_nreq", req_log.size(), 4);
    repeat (10) cyc();

    // Jump at address 3 stops prefetch until redirect
    load_mem(0);
    mem[3] = 8'hC1;
    lat_mode = -1;
    do_reset(2);
    dec_ready = 1'b1;
    repeat (40) cyc();
    chk("t3_nreq", req_log.size(), 4);
    chk("t3_req_idle", imem_req, 0);
    chk("t3_pops", pops, 4);
    chk("t3_last_pc", last_pc, 3);
    chk("t3_busy", busy, 0);
    redirect_valid = 1'b1;
    redirect_target = 8'h10;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10 && req_log.size() < 5; i++) cyc();
    if (req_log.size() >= 5) chk("t3_target", req_log[4], 8'h10);
    else chk("t3_nreq_after", req_log.size(), 5);
    repeat (10) cyc();

    // Redirect while a slow request is outstanding
    load_mem(0);
    lat_mode = 3;
    do_reset(2);
    dec_ready = 1'b1;
    for (int i = 0; i < 10 && !imem_req; i++) cyc();
    chk("t4_wait", imem_req, 1);
    redirect_valid = 1'b1;
    redirect_target = 8'h40;
    cyc();
    redirect_valid = 1'b0;
    chk("t4_still_out", imem_req, 1);
    chk("t4_valid", dec_valid, 0);
    for (int i = 0; i < 20 && req_log.size() < 2; i++) cyc();
    if (req_log.size() >= 2) chk("t4_target", req_log[1], 8'h40);
    else chk("t4_nreq", req_log.size(), 2);
    repeat (15) cyc();
    chk("t4_pops", pops >= 1, 1);

    // PC wrap at 8'hFF, then reset in the middle of a request
    lat_mode = 1;
    do_reset(2);
    redirect_valid = 1'b1;
    redirect_target = 8'hFF;
    dec_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && req_log.size() < 2; i++) cyc();
    chk("t6_nreq", req_log.size() >= 2, 1);
    if (req_log.size() >= 2) begin
      chk("t6_ff", req_log[0], 8'hFF);
      chk("t6_wrap", req_log[1], 8'h00);
    end
    for (int i = 0; i < 10 && !(imem_req && !imem_ack); i++) cyc();
    chk("t6_mid_wait", imem_req, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6_req", imem_req, 0);
    chk("t6_valid", dec_valid, 0);
    chk("t6_busy", busy, 0);

    // Random traffic with random latency, backpressure and redirects
    load_mem(1);
    lat_mode = -1;
    do_reset(2);
    idle = 0;
    for (int n = 0; n < 1500; n++) begin
      cyc();
      if (!imem_req && !dec_valid) idle++;
      else idle = 0;
      dec_ready = ($urandom % 4) != 0;
      if (idle > 6 || ($urandom % 50) == 0) begin
        redirect_valid = 1'b1;
        redirect_target = 8'($urandom);
        idle = 0;
      end else begin
        redirect_valid = 1'b0;
      end
    end
    redirect_valid = 1'b0;
    cyc();
    chk("rand_progress", pops > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
